// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package loader_pkg;

  typedef enum logic [2:0] {
    StSync,
    StCount,
    StData,
    StCheck,
    StDone,
    StErr
  } state_e;

  localparam logic [7:0] SyncByteDefault = 8'hA5;

endpackage

// File: rtl/instr_loader.sv
// Receives a framed byte stream, writes little-endian words into instruction RAM and
// holds the CPU in reset until a complete image with a matching XOR checksum has landed.
module instr_loader
  import loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter logic [7:0]  SYNC_BYTE = SyncByteDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] instr_wAddr,
  output logic [31:0] instr_wData,
  output logic        instr_we,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam int unsigned IdxW     = $clog2(DEPTH) + 1;
  localparam logic [7:0]  MaxCount = 8'(DEPTH);

  state_e            r_state_q, w_state_d;
  logic [IdxW-1:0]   r_cnt_q, w_cnt_d;
  logic [IdxW-1:0]   r_widx_q, w_widx_d;
  logic [1:0]        r_bidx_q, w_bidx_d;
  logic [7:0]        r_chk_q, w_chk_d;
  logic [23:0]       r_asm_q, w_asm_d;
  logic              r_we_q, w_we_d;
  logic [31:0]       r_waddr_q, w_waddr_d;
  logic [31:0]       r_wdata_q, w_wdata_d;
  logic              r_hold_q, w_hold_d;
  logic              r_done_q, w_done_d;
  logic              r_err_q, w_err_d;
  logic              w_fire;
  logic              w_is_sync;
  logic [IdxW-1:0]   w_widx_inc;

  // The RAM takes a write every cycle, so the only time we refuse bytes is under reset.
  assign rx_ready   = ~reset;
  assign w_fire     = rx_valid & rx_ready;
  assign w_is_sync  = (rx_data == SYNC_BYTE);
  assign w_widx_inc = r_widx_q + IdxW'(1);

  always_comb begin
    w_state_d = r_state_q;
    w_cnt_d   = r_cnt_q;
    w_widx_d  = r_widx_q;
    w_bidx_d  = r_bidx_q;
    w_chk_d   = r_chk_q;
    w_asm_d   = r_asm_q;
    w_we_d    = 1'b0;
    w_waddr_d = r_waddr_q;
    w_wdata_d = r_wdata_q;
    w_hold_d  = r_hold_q;
    w_done_d  = r_done_q;
    w_err_d   = r_err_q;

    unique case (r_state_q)
      StSync: begin
        if (w_fire && w_is_sync) w_state_d = StCount;
      end
      StCount: begin
        if (w_fire) begin
          if ((rx_data == 8'd0) || (rx_data > MaxCount)) begin
            w_state_d = StErr;
            w_err_d   = 1'b1;
            w_hold_d  = 1'b1;
          end else begin
            w_state_d = StData;
            w_cnt_d   = IdxW'(rx_data);
            w_widx_d  = '0;
            w_bidx_d  = '0;
            w_chk_d   = '0;
          end
        end
      end
      StData: begin
        if (w_fire) begin
          w_asm_d  = {rx_data, r_asm_q[23:8]};
          w_chk_d  = r_chk_q ^ rx_data;
          w_bidx_d = r_bidx_q + 2'd1;
          if (r_bidx_q == 2'd3) begin
            w_we_d    = 1'b1;
            w_waddr_d = 32'({r_widx_q, 2'b00});
            w_wdata_d = {rx_data, r_asm_q};
            w_widx_d  = w_widx_inc;
            if (w_widx_inc == r_cnt_q) w_state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (w_fire) begin
          if (rx_data == r_chk_q) begin
            w_state_d = StDone;
            w_done_d  = 1'b1;
            w_hold_d  = 1'b0;
          end else begin
            w_state_d = StErr;
            w_err_d   = 1'b1;
            w_hold_d  = 1'b1;
          end
        end
      end
      StDone, StErr: begin
        // A fresh sync byte re-arms the loader and re-asserts the CPU hold.
        if (w_fire && w_is_sync) begin
          w_state_d = StCount;
          w_hold_d  = 1'b1;
          w_done_d  = 1'b0;
          w_err_d   = 1'b0;
        end
      end
      default: w_state_d = StSync;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state_q <= StSync;
      r_cnt_q   <= '0;
      r_widx_q  <= '0;
      r_bidx_q  <= '0;
      r_chk_q   <= '0;
      r_asm_q   <= '0;
      r_we_q    <= 1'b0;
      r_waddr_q <= '0;
      r_wdata_q <= '0;
      r_hold_q  <= 1'b1;
      r_done_q  <= 1'b0;
      r_err_q   <= 1'b0;
    end else begin
      r_state_q <= w_state_d;
      r_cnt_q   <= w_cnt_d;
      r_widx_q  <= w_widx_d;
      r_bidx_q  <= w_bidx_d;
      r_chk_q   <= w_chk_d;
      r_asm_q   <= w_asm_d;
      r_we_q    <= w_we_d;
      r_waddr_q <= w_waddr_d;
      r_wdata_q <= w_wdata_d;
      r_hold_q  <= w_hold_d;
      r_done_q  <= w_done_d;
      r_err_q   <= w_err_d;
    end
  end

  assign instr_we    = r_we_q;
  assign instr_wAddr = r_waddr_q;
  assign instr_wData = r_wdata_q;
  assign cpu_hold    = r_hold_q;
  assign load_done   = r_done_q;
  assign load_err    = r_err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: frame-level reference model plus per-cycle compare.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [31:0] instr_wAddr;
  logic [31:0] instr_wData;
  logic        instr_we;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  always #5 clk = ~clk;

  instr_loader #(
    .DEPTH    (64),
    .SYNC_BYTE(8'hA5)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .instr_wAddr(instr_wAddr),
    .instr_wData(instr_wData),
    .instr_we   (instr_we),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  logic        exp_hold = 1'b1;
  logic        exp_done = 1'b0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  logic [31:0] fw[0:63];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model's expected flags and write queue.
  always @(negedge clk) begin
    logic [31:0] ea, ed;
    check("rx_ready", 32'(rx_ready), 32'(!reset));
    check("cpu_hold", 32'(cpu_hold), 32'(exp_hold));
    check("load_done", 32'(load_done), 32'(exp_done));
    check("load_err", 32'(load_err), 32'(exp_err));
    check("instr_we", 32'(instr_we), 32'(exp_addr_q.size() != 0));
    if (instr_we) begin
      obs_addr.push_back(instr_wAddr);
      obs_data.push_back(instr_wData);
    end
    if (exp_addr_q.size() != 0) begin
      ea = exp_addr_q.pop_front();
      ed = exp_data_q.pop_front();
      if (instr_we) begin
        check("instr_wAddr", instr_wAddr, ea);
        check("instr_wData", instr_wData, ed);
      end
    end
  end

  // Drive one byte with a random idle gap; returns 1 time unit after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int g;
    g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    repeat (g) begin
      rx_valid = 1'b0;
      rx_data  = 8'hA5;
      @(posedge clk);
      #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'hA5;
  endtask

  // Sends a full frame built from fw[]; chk_xor != 0 corrupts the checksum byte.
  task automatic send_frame(input logic [7:0] cnt, input logic [7:0] chk_xor, input int maxgap);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    send_byte(8'hA5, maxgap);
    exp_hold = 1'b1;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    send_byte(cnt, maxgap);
    if (cnt == 8'd0 || cnt > 8'd64) begin
      exp_err = 1'b1;
      return;
    end
    for (int k = 0; k < int'(cnt); k++) begin
      for (int j = 0; j < 4; j++) begin
        b = fw[k][8*j +: 8];
        x = x ^ b;
        send_byte(b, maxgap);
      end
      exp_addr_q.push_back(32'(4 * k));
      exp_data_q.push_back(fw[k]);
    end
    send_byte(x ^ chk_xor, maxgap);
    if (chk_xor == 8'h00) begin
      exp_done = 1'b1;
      exp_hold = 1'b0;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic send_noise(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(255, 0));
      if (b == 8'hA5) b = 8'h00;
      send_byte(b, 1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_we"}, 32'(instr_we), 32'd0);
    check({tag, "_waddr"}, instr_wAddr, 32'd0);
    check({tag, "_wdata"}, instr_wData, 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_done"}, 32'(load_done), 32'd0);
    check({tag, "_err"}, 32'(load_err), 32'd0);
  endtask

  initial begin
    int sz;
    int cnt;
    #1 reset = 1'b1;
    #2 check_reset_outputs("reset0");
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;

    // Single word.
    fw[0] = 32'h0000_0013;
    send_frame(8'd1, 8'h00, 0);
    check("single_data", obs_data[$], 32'h0000_0013);
    check("single_addr", obs_addr[$], 32'h0);
    check("single_done", 32'(load_done), 32'd1);
    check("single_hold", 32'(cpu_hold), 32'd0);

    // Two words with gaps.
    fw[0] = 32'h0020_8AB3;
    fw[1] = 32'h00C0_8083;
    send_frame(8'd2, 8'h00, 3);
    check("two_data0", obs_data[obs_data.size()-2], 32'h0020_8AB3);
    check("two_addr0", obs_addr[obs_addr.size()-2], 32'h0);
    check("two_data1", obs_data[$], 32'h00C0_8083);
    check("two_addr1", obs_addr[$], 32'h4);
    check("two_done", 32'(load_done), 32'd1);

    // Bad checksum: CHK sent as 00.
    fw[0] = 32'h0000_0013;
    sz = obs_data.size();
    send_frame(8'd1, 8'h13, 1);
    check("badchk_write", 32'(obs_data.size()), 32'(sz + 1));
    check("badchk_err", 32'(load_err), 32'd1);
    check("badchk_hold", 32'(cpu_hold), 32'd1);
    check("badchk_done", 32'(load_done), 32'd0);

    // Bad counts.
    sz = obs_data.size();
    send_frame(8'd0, 8'h00, 1);
    check("cnt0_err", 32'(load_err), 32'd1);
    send_frame(8'h41, 8'h00, 1);
    check("cnt65_err", 32'(load_err), 32'd1);
    check("badcnt_nowrite", 32'(obs_data.size()), 32'(sz));

    // Noise in DONE is ignored; then restart.
    fw[0] = 32'h0000_0013;
    send_frame(8'd1, 8'h00, 0);
    send_byte(8'hFF, 1);
    send_byte(8'h12, 1);
    check("noise_done", 32'(load_done), 32'd1);
    send_byte(8'hA5, 0);
    exp_hold = 1'b1;
    exp_done = 1'b0;
    @(negedge clk);
    check("restart_hold", 32'(cpu_hold), 32'd1);
    check("restart_done", 32'(load_done), 32'd0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) fw[k] = $urandom;
    // Finish the restarted frame byte-by-byte (sync already sent).
    begin
      logic [7:0] x;
      x = 8'h00;
      send_byte(8'd3, 1);
      for (int k = 0; k < 3; k++) begin
        for (int j = 0; j < 4; j++) begin
          x = x ^ fw[k][8*j +: 8];
          send_byte(fw[k][8*j +: 8], 1);
        end
        exp_addr_q.push_back(32'(4 * k));
        exp_data_q.push_back(fw[k]);
      end
      send_byte(x, 1);
      exp_done = 1'b1;
      exp_hold = 1'b0;
    end

    // Async reset mid-frame after two data bytes.
    sz = obs_data.size();
    send_byte(8'hA5, 0);
    exp_hold = 1'b1;
    exp_done = 1'b0;
    send_byte(8'd1, 0);
    send_byte(8'h37, 0);
    send_byte(8'h12, 0);
    #2 reset = 1'b1;
    exp_hold = 1'b1;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_nowrite", 32'(obs_data.size()), 32'(sz));
    send_noise(2);
    fw[0] = 32'hDEAD_BEEF;
    send_frame(8'd1, 8'h00, 1);
    check("postreset_data", obs_data[$], 32'hDEAD_BEEF);

    // Largest accepted image.
    for (int k = 0; k < 64; k++) fw[k] = $urandom;
    send_frame(8'd64, 8'h00, 0);
    check("depth_addr", obs_addr[$], 32'd252);

    // Randomized frames.
    for (int it = 0; it < 25; it++) begin
      send_noise(int'($urandom_range(2, 0)));
      if ($urandom_range(9, 0) == 0) begin
        cnt = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(255, 65));
        send_frame(8'(cnt), 8'h00, 2);
      end else begin
        cnt = int'($urandom_range(8, 1));
        for (int k = 0; k < cnt; k++) fw[k] = $urandom;
        send_frame(8'(cnt), ($urandom_range(4, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00, 2);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("writes_drained", 32'(exp_addr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
